// File: rtl/ivl_uvm_ovl_clk_div_ctrl.sv
// Programmable clock-divider controller.
// Produces a registered divided clock plus a one-cycle period-start enable.
// Start and stop happen only on period boundaries, so clk_out never emits a runt pulse.
// A valid/ready port changes the divide ratio at run time; a new ratio takes effect
// only when a period wraps.
module ivl_uvm_ovl_clk_div_ctrl #(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 10,
    parameter int MIN_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_cfg_valid,
    input  logic [DIV_W-1:0] i_cfg_div,
    output logic             o_cfg_ready,
    output logic             o_cfg_err,
    output logic             o_clk_out,
    output logic             o_clk_en,
    output logic             o_busy,
    output logic [DIV_W-1:0] o_edge_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] ONE_V     = DIV_W'(1);

    state_t           r_state, w_state_next;
    logic [DIV_W-1:0] r_cnt, w_cnt_next;
    logic [DIV_W-1:0] r_div, w_div_next;
    logic [DIV_W-1:0] r_pend, w_pend_next;
    logic             r_pend_v, w_pend_v_next;
    logic             r_cfg_err, w_cfg_err_next;
    logic             r_clk_out, w_clk_out_next;
    logic             r_clk_en, w_clk_en_next;
    logic [DIV_W-1:0] r_edge_cnt, w_edge_cnt_next;

    logic             w_wrap;
    logic             w_xfer;
    logic             w_busy_next;
    logic [DIV_W:0]   w_hi_next;

    // Last cycle of a period while the counter is active.
    assign w_wrap = (r_state != ST_IDLE) && (r_cnt == (r_div - ONE_V));
    assign w_xfer = i_cfg_valid && !r_pend_v;

    // Next-state, counter, ratio and output-flop inputs; outputs are computed from
    // next-state values so every output comes straight from a flop.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_div_next     = r_div;
        w_pend_next    = r_pend;
        w_pend_v_next  = r_pend_v;
        w_cfg_err_next = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                if (i_run) begin
                    w_state_next = ST_RUN;
                end
                if (r_pend_v) begin
                    w_div_next    = r_pend;
                    w_pend_v_next = 1'b0;
                end
            end
            ST_RUN, ST_STOP: begin
                w_cnt_next = w_wrap ? '0 : (r_cnt + ONE_V);
                if (w_wrap && r_pend_v) begin
                    w_div_next    = r_pend;
                    w_pend_v_next = 1'b0;
                end
                if (r_state == ST_RUN) begin
                    if (!i_run) begin
                        w_state_next = ST_STOP;
                    end
                end else if (i_run) begin
                    w_state_next = ST_RUN;
                end else if (w_wrap) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase

        // Only reachable when no ratio is pending, so it never collides with an apply above.
        if (w_xfer) begin
            if (i_cfg_div < MIN_DIV_V) begin
                w_cfg_err_next = 1'b1;
            end else begin
                w_pend_next   = i_cfg_div;
                w_pend_v_next = 1'b1;
            end
        end

        // Odd ratios give the extra cycle to the high phase.
        w_busy_next     = (w_state_next != ST_IDLE);
        w_hi_next       = ({1'b0, w_div_next} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        w_clk_out_next  = w_busy_next && ({1'b0, w_cnt_next} < w_hi_next);
        w_clk_en_next   = w_busy_next && (w_cnt_next == '0);
        w_edge_cnt_next = r_edge_cnt + {{(DIV_W-1){1'b0}}, w_clk_en_next};
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_div      <= DEF_DIV_V;
            r_pend     <= '0;
            r_pend_v   <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_clk_out  <= 1'b0;
            r_clk_en   <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_div      <= w_div_next;
            r_pend     <= w_pend_next;
            r_pend_v   <= w_pend_v_next;
            r_cfg_err  <= w_cfg_err_next;
            r_clk_out  <= w_clk_out_next;
            r_clk_en   <= w_clk_en_next;
            r_edge_cnt <= w_edge_cnt_next;
        end
    end

    assign o_cfg_ready = !r_pend_v;
    assign o_cfg_err   = r_cfg_err;
    assign o_clk_out   = r_clk_out;
    assign o_clk_en    = r_clk_en;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_edge_cnt  = r_edge_cnt;

endmodule

// File: tb/tb_ivl_uvm_ovl_clk_div_ctrl.sv
// Self-checking bench for ivl_uvm_ovl_clk_div_ctrl: a per-cycle vector table plus
// hand-written sequences for start-up, reconfiguration, stop/restart and async reset.
module tb_ivl_uvm_ovl_clk_div_ctrl;

    localparam int DIV_W = 16;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clk_out;
    logic             clk_en;
    logic             busy;
    logic [DIV_W-1:0] edge_cnt;

    int n_checks = 0;
    int n_err    = 0;

    ivl_uvm_ovl_clk_div_ctrl #(
        .DIV_W  (DIV_W),
        .DEF_DIV(10),
        .MIN_DIV(2)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_run      (run),
        .i_cfg_valid(cfg_valid),
        .i_cfg_div  (cfg_div),
        .o_cfg_ready(cfg_ready),
        .o_cfg_err  (cfg_err),
        .o_clk_out  (clk_out),
        .o_clk_en   (clk_en),
        .o_busy     (busy),
        .o_edge_cnt (edge_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             run;
        logic             valid;
        logic [DIV_W-1:0] div;
        logic             out;
        logic             en;
        logic             bsy;
        logic             rdy;
        logic             err;
        logic [DIV_W-1:0] ecnt;
    } vec_t;

    vec_t vt [24];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Expected clk_out/clk_en/busy for a given phase within an N-cycle period.
    task automatic chk_phase(input string tag, input int ph, input int n, input bit exp_busy);
        int hi;
        hi = (n + 1) / 2;
        chk({tag, ".clk_out"}, int'(clk_out), int'(exp_busy && (ph < hi)));
        chk({tag, ".clk_en"},  int'(clk_en),  int'(exp_busy && (ph == 0)));
        chk({tag, ".busy"},    int'(busy),    int'(exp_busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        rst_n     = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        repeat (2) @(negedge clk);
        chk("rst.clk_out",   int'(clk_out),   0);
        chk("rst.clk_en",    int'(clk_en),    0);
        chk("rst.busy",      int'(busy),      0);
        chk("rst.cfg_ready", int'(cfg_ready), 1);
        chk("rst.cfg_err",   int'(cfg_err),   0);
        chk("rst.edge_cnt",  int'(edge_cnt),  0);
        $display("reset state checked");
        rst_n = 1'b1;

        // ---------------- A: default ratio, run held ----------------
        run = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            chk_phase("A", i % 10, 10, 1'b1);
            if (i < 29) tick();
        end
        chk("A.edge_cnt30", int'(edge_cnt), 3);
        $display("seq A: N=10 for 30 cycles, edge_cnt=%0d", edge_cnt);

        // ---------------- table: N=5 in IDLE, bad ratio, stop on wrap, N=3 ----------------
        //                run   vld   div      out   en    busy  rdy   err   ecnt
        vt[0]  = '{1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vt[1]  = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        vt[2]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
        vt[3]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        vt[4]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        vt[5]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        vt[6]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1};
        vt[7]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2};
        vt[8]  = '{1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2};
        vt[9]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
        vt[10] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
        vt[11] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2};
        vt[12] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3};
        vt[13] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3};
        vt[14] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3};
        vt[15] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3};
        vt[16] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd3};
        vt[17] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
        vt[18] = '{1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3};
        vt[19] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd3};
        vt[20] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
        vt[21] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4};
        vt[22] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd4};
        vt[23] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'd5};

        do_reset();
        for (int v = 0; v < 24; v++) begin
            run       = vt[v].run;
            cfg_valid = vt[v].valid;
            cfg_div   = vt[v].div;
            tick();
            chk($sformatf("T%0d.clk_out", v),   int'(clk_out),   int'(vt[v].out));
            chk($sformatf("T%0d.clk_en", v),    int'(clk_en),    int'(vt[v].en));
            chk($sformatf("T%0d.busy", v),      int'(busy),      int'(vt[v].bsy));
            chk($sformatf("T%0d.cfg_ready", v), int'(cfg_ready), int'(vt[v].rdy));
            chk($sformatf("T%0d.cfg_err", v),   int'(cfg_err),   int'(vt[v].err));
            chk($sformatf("T%0d.edge_cnt", v),  int'(edge_cnt),  int'(vt[v].ecnt));
            $display("vec %0d: run=%0b vld=%0b div=%0d -> out=%0b en=%0b busy=%0b rdy=%0b err=%0b ecnt=%0d",
                     v, vt[v].run, vt[v].valid, vt[v].div, clk_out, clk_en, busy, cfg_ready, cfg_err, edge_cnt);
        end
        cfg_valid = 1'b0;

        // ---------------- B: reconfigure 10 -> 4 mid-period ----------------
        do_reset();
        run = 1'b1;
        tick();
        for (int i = 0; i < 22; i++) begin
            int n;
            int ph;
            n  = (i < 10) ? 10 : 4;
            ph = (i < 10) ? i : ((i - 10) % 4);
            chk_phase($sformatf("B%0d", i), ph, n, 1'b1);
            chk($sformatf("B%0d.cfg_ready", i), int'(cfg_ready), int'(!(i >= 4 && i <= 9)));
            if (i == 3) begin
                cfg_valid = 1'b1;
                cfg_div   = 16'd4;
            end else begin
                cfg_valid = 1'b0;
            end
            if (i < 21) tick();
        end
        $display("seq B: ratio 10 -> 4 applied at wrap");

        // ---------------- D: async reset during a high phase ----------------
        tick();
        chk("D.pre_high", int'(clk_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("D.async.clk_out",  int'(clk_out),  0);
        chk("D.async.busy",     int'(busy),     0);
        chk("D.async.edge_cnt", int'(edge_cnt), 0);
        chk("D.async.clk_en",   int'(clk_en),   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            chk_phase($sformatf("D%0d", i), i % 10, 10, 1'b1);
            if (i == 0)  chk("D.edge_cnt0",  int'(edge_cnt), 1);
            if (i == 10) chk("D.edge_cnt10", int'(edge_cnt), 2);
            if (i < 11) tick();
        end
        $display("seq D: async reset restarts with default ratio");

        // ---------------- C: stop/re-raise without gap, then stop at end of period ----------------
        do_reset();
        run = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            chk_phase($sformatf("C%0d", i), i % 10, 10, i <= 29);
            if (i == 29) chk("C.edge_cnt29", int'(edge_cnt), 3);
            if (i == 31) chk("C.edge_cnt31", int'(edge_cnt), 3);
            if (i == 2)  run = 1'b0;
            if (i == 6)  run = 1'b1;
            if (i == 22) run = 1'b0;
            if (i < 31) tick();
        end
        $display("seq C: run dip without gap, then clean stop");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
